// File: rtl/add_game_pkg.sv
// Shared types and constants for the two-row card-addition game.
package add_game_pkg;

    localparam int NUM_ROWS  = 2;
    localparam int MAX_COLS  = 5;
    localparam int CARD_W    = 4;
    localparam int NUM_CARDS = NUM_ROWS * MAX_COLS;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    typedef enum logic [2:0] {
        IDLE,
        PICK1,
        PICK2,
        EVAL,
        CHECK,
        OVER
    } state_t;

    // Cards are decimal digits, so the 5-bit sum never exceeds 18.
    function automatic logic [3:0] digit_sum_mod10(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
    endfunction

endpackage

// File: rtl/add_cursor_nav.sv
// Cursor over the active cells of the 2-row board, with wrap and direction priority.
module add_cursor_nav #(
    parameter int MAX_COLS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic [3:0] dir,
    input  logic [2:0] num_cols,
    output logic [3:0] cursor
);
    import add_game_pkg::*;

    localparam logic [3:0] ROW_STRIDE = 4'(MAX_COLS);

    logic       r_row;
    logic [2:0] r_col;
    logic [2:0] w_last_col;

    assign w_last_col = num_cols - 3'd1;

    // With two rows, up and down both toggle the row; left/right walk the linear order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= 1'b0;
            r_col <= 3'd0;
        end else if (clear) begin
            r_row <= 1'b0;
            r_col <= 3'd0;
        end else if (enable) begin
            if (dir[DIR_UP] || dir[DIR_DOWN]) begin
                r_row <= ~r_row;
            end else if (dir[DIR_LEFT]) begin
                if (r_col == 3'd0) begin
                    r_row <= ~r_row;
                    r_col <= w_last_col;
                end else begin
                    r_col <= r_col - 3'd1;
                end
            end else if (dir[DIR_RIGHT]) begin
                if (r_col >= w_last_col) begin
                    r_row <= ~r_row;
                    r_col <= 3'd0;
                end else begin
                    r_col <= r_col + 3'd1;
                end
            end
        end
    end

    assign cursor = r_row ? (ROW_STRIDE + {1'b0, r_col}) : {1'b0, r_col};

endmodule

// File: rtl/add_round_ctrl.sv
// Round sequencer: board, two-pick selection, (a+b) mod 10 evaluation, score and countdown.
module add_round_ctrl #(
    parameter int TIME_LIMIT = 30,
    parameter int MAX_COLS   = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick_1hz,
    input  logic                    start,
    input  logic                    confirm,
    input  logic [3:0]              dir,
    input  logic [2:0]              num_cols,
    input  logic [3:0]              target,
    input  logic [2*MAX_COLS*4-1:0] status_in,
    output logic [2*MAX_COLS*4-1:0] status,
    output logic [3:0]              cursor,
    output logic [3:0]              first_idx,
    output logic                    first_valid,
    output logic [3:0]              result,
    output logic                    result_valid,
    output logic                    match,
    output logic [7:0]              score,
    output logic [5:0]              time_left,
    output logic                    game_over
);
    import add_game_pkg::*;

    localparam int         CELLS      = NUM_ROWS * MAX_COLS;
    localparam int         BOARD_W    = CELLS * CARD_W;
    localparam logic [2:0] MAX_COLS_L = 3'(MAX_COLS);
    localparam logic [5:0] TIME_INIT  = 6'(TIME_LIMIT);

    state_t               r_state,        w_state_next;
    logic [BOARD_W-1:0]   r_status,       w_status_next;
    logic [2:0]           r_num_cols,     w_num_cols_next;
    logic [3:0]           r_target,       w_target_next;
    logic [3:0]           r_first_idx,    w_first_idx_next;
    logic [3:0]           r_second_idx,   w_second_idx_next;
    logic                 r_first_valid,  w_first_valid_next;
    logic [3:0]           r_result,       w_result_next;
    logic                 r_result_valid, w_result_valid_next;
    logic                 r_match,        w_match_next;
    logic [7:0]           r_score,        w_score_next;
    logic [5:0]           r_time_left,    w_time_left_next;

    logic [3:0]           w_cursor;
    logic                 w_nav_en;
    logic [2:0]           w_ncols_clamp;
    logic [BOARD_W-1:0]   w_load;
    logic [CARD_W-1:0]    w_cur_card;
    logic [CARD_W-1:0]    w_card_a;
    logic [CARD_W-1:0]    w_card_b;
    logic [3:0]           w_eval_result;
    logic                 w_eval_match;

    assign w_ncols_clamp = (num_cols == 3'd0 || num_cols > MAX_COLS_L) ? MAX_COLS_L : num_cols;

    // Cells in columns beyond the requested width load as consumed.
    for (genvar gi = 0; gi < CELLS; gi++) begin : g_load
        localparam logic [2:0] COL = 3'(gi % MAX_COLS);
        assign w_load[gi*CARD_W +: CARD_W] =
            (COL < w_ncols_clamp) ? status_in[gi*CARD_W +: CARD_W] : '0;
    end

    assign w_nav_en = (r_state == PICK1) || (r_state == PICK2);

    add_cursor_nav #(
        .MAX_COLS (MAX_COLS)
    ) u_nav (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start),
        .enable   (w_nav_en),
        .dir      (dir),
        .num_cols (r_num_cols),
        .cursor   (w_cursor)
    );

    assign w_cur_card    = r_status[{w_cursor, 2'b00} +: CARD_W];
    assign w_card_a      = r_status[{r_first_idx, 2'b00} +: CARD_W];
    assign w_card_b      = r_status[{r_second_idx, 2'b00} +: CARD_W];
    assign w_eval_result = digit_sum_mod10(w_card_a, w_card_b);
    assign w_eval_match  = (w_eval_result == r_target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_status       <= '0;
            r_num_cols     <= MAX_COLS_L;
            r_target       <= 4'd0;
            r_first_idx    <= 4'd0;
            r_second_idx   <= 4'd0;
            r_first_valid  <= 1'b0;
            r_result       <= 4'd0;
            r_result_valid <= 1'b0;
            r_match        <= 1'b0;
            r_score        <= 8'd0;
            r_time_left    <= 6'd0;
        end else begin
            r_state        <= w_state_next;
            r_status       <= w_status_next;
            r_num_cols     <= w_num_cols_next;
            r_target       <= w_target_next;
            r_first_idx    <= w_first_idx_next;
            r_second_idx   <= w_second_idx_next;
            r_first_valid  <= w_first_valid_next;
            r_result       <= w_result_next;
            r_result_valid <= w_result_valid_next;
            r_match        <= w_match_next;
            r_score        <= w_score_next;
            r_time_left    <= w_time_left_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_status_next       = r_status;
        w_num_cols_next     = r_num_cols;
        w_target_next       = r_target;
        w_first_idx_next    = r_first_idx;
        w_second_idx_next   = r_second_idx;
        w_first_valid_next  = r_first_valid;
        w_result_next       = r_result;
        w_result_valid_next = 1'b0;
        w_match_next        = 1'b0;
        w_score_next        = r_score;
        w_time_left_next    = r_time_left;

        if (start) begin
            w_state_next       = PICK1;
            w_status_next      = w_load;
            w_num_cols_next    = w_ncols_clamp;
            w_target_next      = target;
            w_time_left_next   = TIME_INIT;
            w_score_next       = 8'd0;
            w_first_valid_next = 1'b0;
        end else begin
            case (r_state)
                PICK1, PICK2: begin
                    if (tick_1hz && r_time_left != 6'd0) begin
                        w_time_left_next = r_time_left - 6'd1;
                    end
                    // An expiring tick takes precedence; any same-cycle confirm is dropped.
                    if (tick_1hz && r_time_left <= 6'd1) begin
                        w_state_next       = OVER;
                        w_first_valid_next = 1'b0;
                    end else if (confirm && w_cur_card != '0) begin
                        if (r_state == PICK1) begin
                            w_first_idx_next   = w_cursor;
                            w_first_valid_next = 1'b1;
                            w_state_next       = PICK2;
                        end else if (w_cursor == r_first_idx) begin
                            w_first_valid_next = 1'b0;
                            w_state_next       = PICK1;
                        end else begin
                            w_second_idx_next  = w_cursor;
                            w_state_next       = EVAL;
                        end
                    end
                end
                EVAL: begin
                    w_result_next       = w_eval_result;
                    w_result_valid_next = 1'b1;
                    w_match_next        = w_eval_match;
                    if (w_eval_match) begin
                        w_status_next[{r_first_idx, 2'b00} +: CARD_W]  = '0;
                        w_status_next[{r_second_idx, 2'b00} +: CARD_W] = '0;
                        w_score_next = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                    end
                    w_first_valid_next = 1'b0;
                    w_state_next       = CHECK;
                end
                CHECK: begin
                    w_state_next = (r_status == '0) ? OVER : PICK1;
                end
                default: begin
                end
            endcase
        end
    end

    assign status       = r_status;
    assign cursor       = w_cursor;
    assign first_idx    = r_first_idx;
    assign first_valid  = r_first_valid;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign match        = r_match;
    assign score        = r_score;
    assign time_left    = r_time_left;
    assign game_over    = (r_state == OVER);

endmodule

// File: tb/tb_add_round_ctrl.sv
// Self-checking bench for add_round_ctrl: cursor vector table plus scoreboarded round sequences.
module tb_add_round_ctrl;

    logic        clk;
    logic        rst_n;
    logic        tick_1hz;
    logic        start;
    logic        confirm;
    logic [3:0]  dir;
    logic [2:0]  num_cols;
    logic [3:0]  target;
    logic [39:0] status_in;
    logic [39:0] status;
    logic [3:0]  cursor;
    logic [3:0]  first_idx;
    logic        first_valid;
    logic [3:0]  result;
    logic        result_valid;
    logic        match;
    logic [7:0]  score;
    logic [5:0]  time_left;
    logic        game_over;

    typedef struct packed {
        logic [3:0] res;
        logic       mat;
    } exp_t;

    typedef struct {
        logic [3:0] mv;
        logic [3:0] exp_cursor;
    } nav_vec_t;

    exp_t     sb_q[$];
    nav_vec_t nav_tbl[13];
    int       n_vec = 0;
    int       n_err = 0;

    localparam logic [3:0] D_UP    = 4'b0001;
    localparam logic [3:0] D_DOWN  = 4'b0010;
    localparam logic [3:0] D_LEFT  = 4'b0100;
    localparam logic [3:0] D_RIGHT = 4'b1000;

    add_round_ctrl #(
        .TIME_LIMIT (2),
        .MAX_COLS   (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_1hz     (tick_1hz),
        .start        (start),
        .confirm      (confirm),
        .dir          (dir),
        .num_cols     (num_cols),
        .target       (target),
        .status_in    (status_in),
        .status       (status),
        .cursor       (cursor),
        .first_idx    (first_idx),
        .first_valid  (first_valid),
        .result       (result),
        .result_valid (result_valid),
        .match        (match),
        .score        (score),
        .time_left    (time_left),
        .game_over    (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle; any result pulse is matched against the scoreboard.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (result_valid) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got result %0d match %0d, expected no result", result, match);
            end else begin
                e = sb_q.pop_front();
                $display("eval: result %0d match %0d (expected %0d/%0d)", result, match, e.res, e.mat);
                chk("eval_result", 128'(result), 128'(e.res));
                chk("eval_match", 128'(match), 128'(e.mat));
            end
        end else if (match) begin
            n_vec++;
            n_err++;
            $display("FAIL match_without_valid: got match 1, expected 0");
        end
    endtask

    task automatic expect_eval(input logic [3:0] r, input logic m);
        exp_t e;
        e.res = r;
        e.mat = m;
        sb_q.push_back(e);
    endtask

    task automatic do_start(input logic [2:0] nc, input logic [3:0] tg, input logic [39:0] cards);
        start     = 1'b1;
        num_cols  = nc;
        target    = tg;
        status_in = cards;
        step();
        start = 1'b0;
    endtask

    task automatic do_dir(input logic [3:0] d);
        dir = d;
        step();
        dir = 4'd0;
    endtask

    task automatic do_confirm();
        confirm = 1'b1;
        step();
        confirm = 1'b0;
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic settle();
        repeat (3) step();
        chk("result_pending", 128'(sb_q.size()), 128'd0);
    endtask

    initial begin
        // num_cols = 3: active cells 0,1,2 and 5,6,7; starts at cursor 0
        nav_tbl[0]  = '{D_LEFT,  4'd7};
        nav_tbl[1]  = '{D_RIGHT, 4'd0};
        nav_tbl[2]  = '{D_DOWN,  4'd5};
        nav_tbl[3]  = '{4'b0101, 4'd0};
        nav_tbl[4]  = '{D_RIGHT, 4'd1};
        nav_tbl[5]  = '{D_RIGHT, 4'd2};
        nav_tbl[6]  = '{D_RIGHT, 4'd5};
        nav_tbl[7]  = '{D_LEFT,  4'd2};
        nav_tbl[8]  = '{4'b1010, 4'd7};
        nav_tbl[9]  = '{4'b1100, 4'd6};
        nav_tbl[10] = '{4'b0000, 4'd6};
        nav_tbl[11] = '{D_RIGHT, 4'd7};
        nav_tbl[12] = '{D_RIGHT, 4'd0};

        rst_n     = 1'b0;
        tick_1hz  = 1'b0;
        start     = 1'b0;
        confirm   = 1'b0;
        dir       = 4'd0;
        num_cols  = 3'd0;
        target    = 4'd0;
        status_in = 40'd0;
        step();
        step();
        chk("reset_outputs", 128'({status, cursor, first_idx, first_valid, result, result_valid,
                                   match, score, time_left, game_over}), 128'd0);
        rst_n = 1'b1;
        step();

        // Matching pair: 3 + 4 = 7
        do_start(3'd5, 4'd7, 40'h0000000143);
        chk("A_load", 128'(status), 128'h0000000143);
        chk("A_time_load", 128'(time_left), 128'd2);
        chk("A_cursor", 128'(cursor), 128'd0);
        chk("A_game_over", 128'(game_over), 128'd0);
        do_confirm();
        chk("A_first_valid", 128'(first_valid), 128'd1);
        chk("A_first_idx", 128'(first_idx), 128'd0);
        do_dir(D_RIGHT);
        chk("A_cursor_right", 128'(cursor), 128'd1);
        expect_eval(4'd7, 1'b1);
        do_confirm();
        settle();
        chk("A_status", 128'(status), 128'h0000000100);
        chk("A_score", 128'(score), 128'd1);
        chk("A_first_valid_clr", 128'(first_valid), 128'd0);

        // Miss with carry: 9 + 5 = 14 -> 4
        do_start(3'd5, 4'd2, 40'h0500009001);
        chk("B_score_clear", 128'(score), 128'd0);
        repeat (3) do_dir(D_RIGHT);
        chk("B_cursor3", 128'(cursor), 128'd3);
        do_confirm();
        do_dir(D_DOWN);
        chk("B_cursor8", 128'(cursor), 128'd8);
        expect_eval(4'd4, 1'b0);
        do_confirm();
        settle();
        chk("B_status", 128'(status), 128'h0500009001);
        chk("B_score", 128'(score), 128'd0);
        chk("B_result_hold", 128'(result), 128'd4);

        // Cursor navigation over a 3-column board, inactive cells masked on load
        do_start(3'd3, 4'd2, 40'h1111111101);
        chk("C_load_mask", 128'(status), 128'h0011100101);
        for (int i = 0; i < 13; i++) begin
            do_dir(nav_tbl[i].mv);
            chk($sformatf("nav%0d", i), 128'(cursor), 128'(nav_tbl[i].exp_cursor));
        end
        do_dir(D_RIGHT);
        do_confirm();
        chk("C_zero_card_pick1", 128'(first_valid), 128'd0);
        do_dir(D_LEFT);
        do_confirm();
        chk("C_pick_first", 128'(first_valid), 128'd1);
        do_confirm();
        chk("C_deselect", 128'(first_valid), 128'd0);
        do_confirm();
        chk("C_reselect", 128'(first_valid), 128'd1);
        do_dir(D_RIGHT);
        do_confirm();
        chk("C_zero_card_pick2", 128'(first_valid), 128'd1);
        chk("C_first_idx_kept", 128'(first_idx), 128'd0);
        do_dir(D_RIGHT);
        expect_eval(4'd2, 1'b1);
        do_confirm();
        settle();
        chk("C_status", 128'(status), 128'h0011100000);
        chk("C_score", 128'(score), 128'd1);

        // Timer expiry drops a same-cycle confirm
        do_start(3'd5, 4'd7, 40'h0000000043);
        do_tick();
        chk("E_time1", 128'(time_left), 128'd1);
        chk("E_not_over", 128'(game_over), 128'd0);
        do_confirm();
        chk("E_first_valid", 128'(first_valid), 128'd1);
        do_dir(D_RIGHT);
        tick_1hz = 1'b1;
        confirm  = 1'b1;
        step();
        tick_1hz = 1'b0;
        confirm  = 1'b0;
        chk("E_game_over", 128'(game_over), 128'd1);
        chk("E_time0", 128'(time_left), 128'd0);
        repeat (3) step();
        chk("E_status_kept", 128'(status), 128'h0000000043);
        chk("E_score", 128'(score), 128'd0);

        // Single column: clearing the board ends the game
        do_start(3'd1, 4'd7, 40'h9999699991);
        chk("F_load_mask", 128'(status), 128'h0000600001);
        do_confirm();
        do_dir(D_DOWN);
        chk("F_cursor5", 128'(cursor), 128'd5);
        expect_eval(4'd7, 1'b1);
        do_confirm();
        settle();
        chk("F_game_over", 128'(game_over), 128'd1);
        chk("F_status", 128'(status), 128'h0);
        chk("F_score", 128'(score), 128'd1);
        do_tick();
        chk("F_time_frozen", 128'(time_left), 128'd2);
        chk("F_result_hold", 128'(result), 128'd7);

        // Asynchronous reset during PICK2
        do_start(3'd5, 4'd7, 40'h0000000043);
        do_confirm();
        chk("G_first_valid", 128'(first_valid), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("G_async_reset", 128'({status, cursor, first_idx, first_valid, result, result_valid,
                                   match, score, time_left, game_over}), 128'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("G_idle_not_over", 128'(game_over), 128'd0);
        do_confirm();
        chk("G_idle_ignores_confirm", 128'(first_valid), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
